alu_serial_loader: RTL

- Parametrised successor to the board-level nibble-entry ALU.
- Operands A and B and an opcode are keyed in one 4-bit nibble at a time on `Datain`, each entry confirmed by an active-low `readNext` push.
- Operand width is configurable; the result is shown on `LEDR` with status flags.
- Sits between the switch/button inputs and the LED drivers of the top level.

---
 rtl/alu_serial_loader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/alu_serial_loader.sv
// Nibble-entry ALU: operands and opcode keyed in 4 bits per push, result on LEDR.
// Optional ALU_ACC_EN adds acc_sel to chain the previous result into A.
module alu_serial_loader #(
  parameter int DATA_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          Datain,
  input  logic                readNext,
`ifdef ALU_ACC_EN
  input  logic                acc_sel,
`endif
  output logic [2*DATA_W-1:0] LEDR,
  output logic [3:0]          flags,
  output logic                res_valid,
  output logic [2:0]          state_o
);

  localparam int W2  = 2 * DATA_W;
  localparam int NIB = DATA_W / 4;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    SHOW    = 3'd4
  } state_t;

  state_t                  r_state;
  logic [2:0]              r_cnt;
  logic [DATA_W-1:0]       r_a;
  logic [DATA_W-1:0]       r_b;
  logic [3:0]              r_op;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic                    r_edge;

  logic                    w_sync;
  logic                    w_ld;
  logic                    w_last;
  logic [DATA_W-1:0]       w_a_shift;
  logic [DATA_W-1:0]       w_b_shift;
  logic [DATA_W-1:0]       w_din;
  logic [W2-1:0]           w_ea;
  logic [W2-1:0]           w_eb;
  logic [31:0]             w_sh;
  logic [W2-1:0]           w_res;
  logic                    w_err;
  logic                    w_carry;
  logic                    w_neg;

  // Button idles high; a released button must not look like a press after reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
      r_edge <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], readNext};
      r_edge <= w_sync;
    end
  end

  assign w_sync    = r_sync[SYNC_STAGES-1];
  assign w_ld      = r_edge & ~w_sync;
  assign w_last    = (r_cnt == 3'(NIB - 1));
  assign w_din     = DATA_W'(Datain);
  assign w_a_shift = (r_a << 4) | w_din;
  assign w_b_shift = (r_b << 4) | w_din;
  assign w_ea      = W2'(r_a);
  assign w_eb      = W2'(r_b);
  assign w_sh      = 32'(r_b) % 32'(W2);

  always_comb begin
    w_res   = '0;
    w_err   = 1'b0;
    w_carry = 1'b0;
    w_neg   = 1'b0;
    case (r_op)
      4'h0: begin
        w_res   = w_ea + w_eb;
        w_carry = w_res[DATA_W];
      end
      4'h1: begin
        w_res   = w_ea - w_eb;
        w_carry = (r_a < r_b);
        w_neg   = w_res[W2-1];
      end
      4'h2: w_res = w_ea * w_eb;
      4'h3: w_res = W2'({r_a > r_b, r_a == r_b, r_a < r_b});
      4'h4: w_res = w_ea & w_eb;
      4'h5: w_res = w_ea | w_eb;
      4'h6: w_res = w_ea ^ w_eb;
      4'h7: w_res = w_ea << w_sh;
      4'h8: w_res = w_ea >> w_sh;
      default: w_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= LOAD_A;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      LEDR      <= '0;
      flags     <= '0;
      res_valid <= 1'b0;
    end else begin
      unique case (r_state)
        LOAD_A: begin
          res_valid <= 1'b0;
          if (w_ld) begin
            r_a <= w_a_shift;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= LOAD_B;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        LOAD_B: begin
          if (w_ld) begin
            r_b <= w_b_shift;
            if (w_last) begin
              r_cnt   <= '0;
              r_state <= LOAD_OP;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        LOAD_OP: begin
          if (w_ld) begin
            r_op    <= Datain;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          LEDR      <= w_res;
          flags     <= {w_err, w_carry, (w_res == '0), w_neg};
          res_valid <= 1'b1;
          r_state   <= SHOW;
        end
        SHOW: begin
          if (w_ld) begin
            res_valid <= 1'b0;
`ifdef ALU_ACC_EN
            if (acc_sel) begin
              r_a <= LEDR[DATA_W-1:0];
              r_b <= w_din;
              if (NIB == 1) begin
                r_cnt   <= '0;
                r_state <= LOAD_OP;
              end else begin
                r_cnt   <= 3'd1;
                r_state <= LOAD_B;
              end
            end else
`endif
            begin
              // With one nibble per operand the push alone completes A
              r_a <= w_din;
              if (NIB == 1) begin
                r_cnt   <= '0;
                r_state <= LOAD_B;
              end else begin
                r_cnt   <= 3'd1;
                r_state <= LOAD_A;
              end
            end
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= LOAD_A;
        end
      endcase
    end
  end

  assign state_o = r_state;

endmodule
